serial_adder_4bit: RTL
======================

SERIAL_ADDER_4BIT -- requirements
Module: serial_adder_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request to add a and b; sampled at rising clk.
REQ-005 Port: a  input  WIDTH  unsigned/two's-complement augend; sampled only when start is accepted.
REQ-006 Port: b  input  WIDTH  addend; sampled only when start is accepted.
REQ-007 Port: busy  output  1  high while an addition is in progress.
REQ-008 Port: done  output  1  single-cycle pulse marking a new valid result.
REQ-009 Port: sum  output  WIDTH  registered result a+b mod 2^WIDTH.
REQ-010 Port: cout  output  1  registered carry out of MSB.
REQ-011 Port: ovf  output  1  registered signed overflow; present only when the Configuration macro is defined.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; the block SHALL be in exactly one state per cycle.
REQ-013 IDLE or DONE with start=1 -> SHIFT: latch a, b into operand shift registers, clear carry register, clear bit counter.
REQ-014 SHIFT, each cycle: SHALL add operand LSBs plus carry register in one full adder, shift sum bit into the work register at MSB, update carry register, shift both operands right one place, increment counter.
REQ-015 SHIFT -> DONE when the counter reaches WIDTH-1 in the same cycle the last bit is processed (exactly WIDTH SHIFT cycles).
REQ-016 Entry into DONE: sum, cout (and ovf) SHALL be loaded from the work register and carry register; done=1 for the DONE cycle only.
REQ-017 DONE with start=0 -> IDLE.
REQ-018 Latency: start accepted at edge N -> done high in cycle after edge N+WIDTH (WIDTH+1 cycles start-to-done); back-to-back start in DONE gives one result every WIDTH+1 cycles.
REQ-019 busy SHALL be 1 exactly in SHIFT.
REQ-020 start while busy=1 SHALL be ignored; a/b changes during SHIFT SHALL not affect the result.
REQ-021 sum/cout/ovf SHALL hold their last values until the next DONE entry; they SHALL not toggle during SHIFT.
REQ-022 Arithmetic: {cout,sum} SHALL equal a+b as a WIDTH+1-bit unsigned value, no truncation other than stated.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, clear shift/carry/counter registers.
REQ-024 Reset mid-SHIFT SHALL abort the operation with no done pulse; first start after rst_n release SHALL behave as from IDLE.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN defined: ovf port exists and equals carry-into-MSB XOR cout of the final bit, loaded at DONE entry.
REQ-026 Macro undefined: no ovf port, no carry-into-MSB storage; all other behaviour identical.

Structure
REQ-027 Shared package adder_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the default width constant (4).
REQ-028 One sub-module, full_adder (inputs a, b, cin; outputs s, cout), SHALL be instantiated once for the bit-slice add.

Verification
REQ-029 WIDTH=4, a=7, b=5, start one cycle -> after 5 cycles done=1, sum=12, cout=0, ovf=1.
REQ-030 a=15, b=1 -> sum=0, cout=1, ovf=0; a=8, b=8 -> sum=0, cout=1, ovf=1.
REQ-031 start held high continuously with a=3, b=4 -> done pulses every 5 cycles, sum=7 each time, busy low only in DONE cycles.
REQ-032 start with a=2, b=2, then start=1 with a=9, b=9 during SHIFT -> single done, sum=4, cout=0; second request ignored.
REQ-033 rst_n pulsed low during 3rd SHIFT cycle -> busy/done/sum/cout all 0 immediately, no done pulse; subsequent a=6, b=1 -> sum=7.
REQ-034 Exhaustive sweep of all 256 (a,b) pairs -> {cout,sum} equals a+b every time; sum stable between done pulses.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder used as the serial bit slice; zero latency, no flow control.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: one bit per cycle, result and done pulse WIDTH+1 cycles after start; start ignored while busy.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_4bit
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] work_q, work_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] work_ext;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign accept   = start && (state_q != SHIFT);
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
    // New sum bit enters at the top; on the last bit this is the complete result.
    assign work_ext = {fa_s, work_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            work_d  = work_ext[WIDTH-1:1];
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
                sum_d  = work_ext;
                cout_d = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                // carry_q is the carry into the MSB while the last bit is added
                ovf_d  = carry_q ^ fa_co;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
